rc4_hls_stream_driver: RTL

// Parametrised host-side driver for the HLS RC4 core (ap_ctrl_hs + ap_fifo ports).

---
 rtl/rc4_drv_pkg.sv | 26 ++
 rtl/rc4_drv_byte_ram.sv | 43 ++++
 rtl/rc4_hls_stream_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rc4_drv_pkg.sv
// Shared types for the RC4 HLS stream driver: job FSM states, sticky error codes
// and the buffer address width derived from the two buffer depths.
package rc4_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_e;

  // One address width serves both buffers so the host write/read ports stay uniform.
  function automatic int addr_width(input int key_depth, input int data_depth);
    int m;
    m = (key_depth > data_depth) ? key_depth : data_depth;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rc4_drv_byte_ram.sv
// Byte buffer with one write port, a combinational read port (FIFO show-ahead)
// and a registered read port (host readback). Contents are never reset.
module rc4_drv_byte_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] araddr,
  output logic [7:0]    ardata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata_q
);

  localparam int IW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [7:0] mem_q [DEPTH];

  // The shared address width can exceed this buffer's depth; such addresses must not alias.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end

  assign ardata = in_range(araddr) ? mem_q[araddr[IW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= in_range(raddr) ? mem_q[raddr[IW-1:0]] : 8'h00;
    end
  end

endmodule

// File: rtl/rc4_hls_stream_driver.sv
// Host-side driver for the HLS RC4 core: holds key/plaintext buffers, feeds the
// ap_fifo inputs for one job per start pulse and captures the ciphertext stream.
module rc4_hls_stream_driver
  import rc4_drv_pkg::*;
#(
  parameter int KEY_DEPTH   = 32,
  parameter int DATA_DEPTH  = 64,
  parameter int TIMEOUT_CYC = 65535,
  localparam int AW = addr_width(KEY_DEPTH, DATA_DEPTH)
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [15:0]   key_len,
  input  logic [31:0]   data_len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [31:0]   ct_count,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          hls_start,
  input  logic          hls_done,
  output logic [7:0]    key_dout,
  output logic          key_empty_n,
  input  logic          key_read,
  output logic [7:0]    pt_dout,
  output logic          pt_empty_n,
  input  logic          pt_read,
  input  logic [7:0]    ct_din,
  output logic          ct_full_n,
  input  logic          ct_write
);

  localparam logic [15:0] KEY_MAX  = 16'(KEY_DEPTH);
  localparam logic [31:0] DATA_MAX = 32'(DATA_DEPTH);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYC - 1);

  state_e      state_q;
  err_e        err_q;
  logic        busy_q;
  logic        done_q;
  logic        hls_start_q;
  logic [15:0] klen_q;
  logic [15:0] kptr_q;
  logic [31:0] plen_q;
  logic [31:0] pptr_q;
  logic [31:0] ccnt_q;
  logic [31:0] wd_q;

  logic       in_run;
  logic       key_acc;
  logic       pt_acc;
  logic       ct_acc;
  logic       progress;
  logic       len_ok;
  logic       key_we;
  logic       pt_we;
  logic [7:0] key_rq;
  logic [7:0] pt_rq;
  logic [7:0] ct_aq;
  logic       unused_rd;

  assign in_run      = (state_q == RUN);
  assign key_empty_n = in_run && (kptr_q < klen_q);
  assign pt_empty_n  = in_run && (pptr_q < plen_q);
  assign ct_full_n   = in_run && (ccnt_q < plen_q);

  assign key_acc  = key_read && key_empty_n;
  assign pt_acc   = pt_read && pt_empty_n;
  assign ct_acc   = ct_write && ct_full_n;
  assign progress = key_acc || pt_acc || ct_acc;

  assign len_ok = (klen_q != 16'd0) && (klen_q <= KEY_MAX) &&
                  (plen_q != 32'd0) && (plen_q <= DATA_MAX);

  assign key_we = wr_en && !busy_q && !wr_sel && (32'(wr_addr) < 32'(KEY_DEPTH));
  assign pt_we  = wr_en && !busy_q &&  wr_sel && (32'(wr_addr) < 32'(DATA_DEPTH));

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign hls_start = hls_start_q;
  assign ct_count  = ccnt_q;

  rc4_drv_byte_ram #(.DEPTH(KEY_DEPTH), .AW(AW)) u_key_ram (
    .clk(ap_clk), .srst(ap_rst),
    .we(key_we), .waddr(wr_addr), .wdata(wr_data),
    .araddr(AW'(kptr_q)), .ardata(key_dout),
    .raddr('0), .rdata_q(key_rq)
  );

  rc4_drv_byte_ram #(.DEPTH(DATA_DEPTH), .AW(AW)) u_pt_ram (
    .clk(ap_clk), .srst(ap_rst),
    .we(pt_we), .waddr(wr_addr), .wdata(wr_data),
    .araddr(AW'(pptr_q)), .ardata(pt_dout),
    .raddr('0), .rdata_q(pt_rq)
  );

  rc4_drv_byte_ram #(.DEPTH(DATA_DEPTH), .AW(AW)) u_ct_ram (
    .clk(ap_clk), .srst(ap_rst),
    .we(ct_acc), .waddr(AW'(ccnt_q)), .wdata(ct_din),
    .araddr('0), .ardata(ct_aq),
    .raddr(rd_addr), .rdata_q(rd_data)
  );

  // Each buffer only needs one of its two read ports.
  assign unused_rd = ^{key_rq, pt_rq, ct_aq};

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      err_q       <= ERR_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hls_start_q <= 1'b0;
      klen_q      <= '0;
      kptr_q      <= '0;
      plen_q      <= '0;
      pptr_q      <= '0;
      ccnt_q      <= '0;
      wd_q        <= '0;
    end else begin
      if (key_acc) kptr_q <= kptr_q + 16'd1;
      if (pt_acc)  pptr_q <= pptr_q + 32'd1;
      if (ct_acc)  ccnt_q <= ccnt_q + 32'd1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CHECK;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
            klen_q  <= key_len;
            plen_q  <= data_len;
            kptr_q  <= '0;
            pptr_q  <= '0;
            ccnt_q  <= '0;
            wd_q    <= '0;
          end
        end
        CHECK: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= ERR_ABORT;
          end else if (len_ok) begin
            state_q     <= RUN;
            hls_start_q <= 1'b1;
            wd_q        <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= ERR_LEN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            hls_start_q <= 1'b0;
            err_q       <= ERR_ABORT;
          end else if (hls_done) begin
            state_q     <= DRAIN;
            hls_start_q <= 1'b0;
            wd_q        <= '0;
          end else if (progress) begin
            wd_q <= '0;
          end else if ((TIMEOUT_CYC != 0) && (wd_q == WD_LAST)) begin
            // wd_q counts silent cycles already elapsed; this is the last allowed one.
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            hls_start_q <= 1'b0;
            err_q       <= ERR_TIMEOUT;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (ccnt_q == plen_q) begin
            done_q <= 1'b1;
          end else begin
            err_q <= ERR_TIMEOUT;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
